// File: rtl/npu_pkg.sv
// Shared NPU definitions: default dimensions, writeback FSM states, result count.
package npu_pkg;

  localparam int unsigned NPU_DATA_W  = 32;
  localparam int unsigned NPU_N       = 3;
  localparam int unsigned NPU_RES_CNT = NPU_N * NPU_N;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } npu_wb_state_t;

endpackage : npu_pkg

// File: rtl/npu_writeback_if.sv
// Valid/ready memory write port carrying one result word per transfer.
interface npu_writeback_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface : npu_writeback_if

// File: rtl/npu_wb_buf.sv
// Result snapshot buffer: parallel load of all words, indexed read.
// Build option NPU_WB_RELU_EN: negative (signed) words are stored as zero.
// The read port bypasses the load data in the load cycle so the first word
// can be presented in the cycle right after capture.
module npu_wb_buf
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = NPU_DATA_W,
  parameter int unsigned DEPTH  = NPU_RES_CNT,
  parameter int unsigned IDX_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld,
  input  logic [DATA_W*DEPTH-1:0] ld_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_data_c
);

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] ld_word [DEPTH];

  // Split the flat load bus into words, applying the optional clamp.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      ld_word[i] = ld_data[i*DATA_W +: DATA_W];
`ifdef NPU_WB_RELU_EN
      if (ld_word[i][DATA_W-1]) begin
        ld_word[i] = '0;
      end
`endif
    end
  end

  // Snapshot storage, written only on a capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (ld) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= ld_word[i];
      end
    end
  end

  // Indexed read with load bypass; out-of-range indices read zero.
  always_comb begin
    rd_data_c = '0;
    if (32'(rd_idx) < DEPTH) begin
      rd_data_c = ld ? ld_word[rd_idx] : mem[rd_idx];
    end
  end

endmodule : npu_wb_buf

// File: rtl/npu_writeback.sv
// NPU writeback: on a rising npu_ack, snapshot the N*N results and drain them
// one word per transfer to consecutive addresses from dst_base, then pulse done.
// Build option NPU_WB_RELU_EN clamps negative results to zero at capture.
module npu_writeback
  import npu_pkg::*;
#(
  parameter int unsigned DATA_W = NPU_DATA_W,
  parameter int unsigned N      = NPU_N,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned STRIDE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      npu_ack,
  input  logic [DATA_W*N*N-1:0]     c_flat,
  input  logic [ADDR_W-1:0]         dst_base,
  npu_writeback_if.master           wr,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned RES_CNT = N * N;
  localparam int unsigned IDX_W   = (RES_CNT > 1) ? $clog2(RES_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RES_CNT - 1);

  npu_wb_state_t     state_q, state_d;
  logic              ack_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              trig_c;
  logic              ld_c;
  logic              accept_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [DATA_W-1:0] rd_data_c;

  assign trig_c   = npu_ack & ~ack_d;
  assign ld_c     = (state_q == IDLE) & trig_c;
  assign accept_c = wr_valid_q & wr.wr_ready;
  // Read ahead to the word that follows the one currently presented.
  assign rd_idx_c = (state_q == DRAIN) ? idx_q + IDX_W'(1) : '0;

  npu_wb_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (RES_CNT),
    .IDX_W  (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld_c),
    .ld_data   (c_flat),
    .rd_idx    (rd_idx_c),
    .rd_data_c (rd_data_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ack_d      <= 1'b0;
      idx_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_d      <= npu_ack;
      idx_q      <= idx_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and next-output logic; outputs hold unless a transfer completes.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig_c) begin
          state_d    = DRAIN;
          idx_d      = '0;
          wr_valid_d = 1'b1;
          wr_addr_d  = dst_base;
          wr_data_d  = rd_data_c;
          busy_d     = 1'b1;
        end
      end
      DRAIN: begin
        if (accept_c) begin
          if (idx_q == LAST_IDX) begin
            state_d    = DONE;
            wr_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            wr_addr_d = wr_addr_q + ADDR_W'(STRIDE);
            wr_data_d = rd_data_c;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d    = IDLE;
        wr_valid_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule : npu_writeback

// File: tb/tb_npu_writeback.sv
// Self-checking bench for npu_writeback: vector table plus address/data scoreboard.
module tb_npu_writeback;
  import npu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RC = NPU_RES_CNT;

  typedef struct {
    logic [AW-1:0] base;
    logic [DW-1:0] w [RC];
    int            stall_word;
    int            stall_cycles;
    bit            toggle_ack;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             npu_ack = 1'b0;
  logic [DW*RC-1:0] c_flat = '0;
  logic [AW-1:0]    dst_base = '0;
  logic             busy;
  logic             done;

  npu_writeback_if #(.ADDR_W(AW), .DATA_W(DW)) wr ();

  npu_writeback #(.DATA_W(DW), .N(NPU_N), .ADDR_W(AW), .STRIDE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .npu_ack  (npu_ack),
    .c_flat   (c_flat),
    .dst_base (dst_base),
    .wr       (wr.master),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  exp_t          exp_q [$];
  vec_t          vecs [5];
  int            acc, cyc, done_cnt, done_cyc, valid_cycles;
  bit            prev_stall;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef NPU_WB_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  // One cycle: drive ready, score any transfer, then advance past the next edge.
  task automatic step(input logic rdy);
    exp_t e;
    if (prev_stall) begin
      chk("hold_valid", 32'(wr.wr_valid), 32'd1);
      chk("hold_addr", wr.wr_addr, prev_addr);
      chk("hold_data", wr.wr_data, prev_data);
    end
    wr.wr_ready = rdy;
    if (wr.wr_valid) valid_cycles++;
    if (wr.wr_valid && rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr=0x%08h data=0x%08h required no write",
                 wr.wr_addr, wr.wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", wr.wr_addr, e.addr);
        chk("wr_data", wr.wr_data, e.data);
      end
      acc++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_stall = wr.wr_valid && !rdy;
    prev_addr  = wr.wr_addr;
    prev_data  = wr.wr_data;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_vec(input vec_t v);
    exp_t e;
    for (int i = 0; i < int'(RC); i++) begin
      c_flat[i*DW +: DW] = v.w[i];
      e.addr = v.base + AW'(i * 4);
      e.data = model_word(v.w[i]);
      exp_q.push_back(e);
    end
    dst_base = v.base;
    acc = 0; cyc = 0; done_cnt = 0; done_cyc = -1; valid_cycles = 0; prev_stall = 1'b0;
  endtask

  // Hold ack high for a 30-cycle window; exactly one drain and one done expected.
  task automatic run_vec(input vec_t v);
    int   stalled;
    logic rdy;
    stalled = 0;
    load_vec(v);
    npu_ack = 1'b1;
    for (int k = 0; k < 30; k++) begin
      if (k == 1) begin
        chk("busy_after_trig", 32'(busy), 32'd1);
        for (int i = 0; i < int'(RC); i++) c_flat[i*DW +: DW] = $urandom;
        dst_base = $urandom;
      end
      if (v.toggle_ack && k == 3) npu_ack = 1'b0;
      if (v.toggle_ack && k == 4) npu_ack = 1'b1;
      rdy = 1'b1;
      if (wr.wr_valid && acc == v.stall_word && stalled < v.stall_cycles) begin
        rdy = 1'b0;
        stalled++;
      end
      step(rdy);
    end
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_latency", 32'(done_cyc), 32'(10 + v.stall_cycles));
    chk("valid_cycles", 32'(valid_cycles), 32'(int'(RC) + v.stall_cycles));
    chk("writes_left", 32'(exp_q.size()), 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    npu_ack = 1'b0;
    step(1'b1);
    step(1'b1);
    exp_q.delete();
  endtask

  initial begin
    // Vector table.
    for (int i = 0; i < int'(RC); i++) begin
      vecs[0].w[i] = DW'(i + 1);
      vecs[1].w[i] = DW'(i + 1);
      vecs[2].w[i] = DW'(32'h10 + i);
      vecs[4].w[i] = DW'(32'hA5A5_0000 + 32'(i * 32'h111));
    end
    vecs[0].base = 32'h100;       vecs[0].stall_word = -1; vecs[0].stall_cycles = 0; vecs[0].toggle_ack = 0;
    vecs[1].base = 32'h100;       vecs[1].stall_word = 4;  vecs[1].stall_cycles = 3; vecs[1].toggle_ack = 0;
    vecs[2].base = 32'hFFFF_FFF8; vecs[2].stall_word = -1; vecs[2].stall_cycles = 0; vecs[2].toggle_ack = 1;
    vecs[3].base = 32'h40;        vecs[3].stall_word = -1; vecs[3].stall_cycles = 0; vecs[3].toggle_ack = 0;
    vecs[3].w[0] = 32'h1;         vecs[3].w[1] = 32'h2;         vecs[3].w[2] = 32'hFFFF_FFFE;
    vecs[3].w[3] = 32'h7;         vecs[3].w[4] = 32'h8000_0000; vecs[3].w[5] = 32'h7FFF_FFFF;
    vecs[3].w[6] = 32'h0;         vecs[3].w[7] = 32'hFFFF_FFFF; vecs[3].w[8] = 32'h5;
    vecs[4].base = 32'h1000;      vecs[4].stall_word = 8;  vecs[4].stall_cycles = 2; vecs[4].toggle_ack = 0;

    wr.wr_ready = 1'b0;
    prev_stall = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_valid", 32'(wr.wr_valid), 32'd0);
    chk("rst_wr_addr", wr.wr_addr, 32'd0);
    chk("rst_wr_data", wr.wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    step(1'b1);

    // wr_ready while idle must not produce a write.
    for (int k = 0; k < 3; k++) step(1'b1);

    for (int t = 0; t < 5; t++) run_vec(vecs[t]);

    // Reset in the middle of a drain, after the 4th accepted write.
    begin
      vec_t vr;
      vr.base = 32'h200; vr.stall_word = -1; vr.stall_cycles = 0; vr.toggle_ack = 0;
      for (int i = 0; i < int'(RC); i++) vr.w[i] = DW'(32'h11 + i);
      load_vec(vr);
      npu_ack = 1'b1;
      for (int k = 0; k < 20 && acc < 4; k++) step(1'b1);
      chk("accepts_before_rst", 32'(acc), 32'd4);
      #1;
      rst = 1'b0;
      npu_ack = 1'b0;
      #1;
      chk("midrst_wr_valid", 32'(wr.wr_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      exp_q.delete();
      prev_stall = 1'b0;
      for (int k = 0; k < 3; k++) step(1'b1);
      rst = 1'b1;
      step(1'b1);
      step(1'b1);
      chk("midrst_no_done", 32'(done_cnt), 32'd0);
    end

    // Fresh trigger after reset drains all words from index 0.
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_npu_writeback

// File: doc/npu_writeback.md
Name: npu_writeback

Overview:
- Downstream stage of the NPU. When the NPU raises ack, this block snapshots the N×N systolic-array results (c1..c9 for N=3).
- It then drains the results one word per transfer over a valid/ready write port into data memory, at consecutive word addresses from a programmable base.
- It signals completion to the controller and holds off re-triggering until ack drops.

Parameters:
- DATA_W, 32, width of one result word.
- N, 3, systolic array dimension; the block handles N*N results.
- ADDR_W, 32, write address width.
- STRIDE, 4, byte increment between consecutive result addresses.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- npu_ack  input  1  NPU ack level; its rising edge triggers a capture.
- c_flat  input  DATA_W*N*N  array results; c1 in bits [DATA_W-1:0], c9 in the top word.
- dst_base  input  ADDR_W  destination base address, sampled at capture.
- wr_valid  output  1  write request valid.
- wr_ready  input  1  memory accepts the write.
- wr_addr  output  ADDR_W  write byte address.
- wr_data  output  DATA_W  write data.
- busy  output  1  high from the capture cycle through the DONE state.
- done  output  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset (rst=0, async): state=IDLE; wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0; index=0; result buffer cleared; ack_d=0.
- ack_d is a registered copy of npu_ack. trig = npu_ack & ~ack_d.
- States: IDLE, DRAIN, DONE.
- IDLE:
  - On trig: capture all N*N words of c_flat into the buffer, latch dst_base, set idx=0, go to DRAIN.
  - busy rises in the cycle after trig.
- DRAIN:
  - wr_valid=1, wr_addr=base + idx*STRIDE (modulo 2^ADDR_W; wrap is silent), wr_data=buf[idx].
  - First wr_valid appears 1 cycle after trig.
  - On wr_valid & wr_ready: if idx==N*N-1 go to DONE, else increment idx and present the next word in the following cycle. Back-to-back transfers are allowed, one per cycle.
  - wr_valid, wr_addr and wr_data stay stable while wr_ready=0. wr_valid never drops before acceptance.
- DONE: done=1 for exactly one cycle, wr_valid=0, then return to IDLE.
- Minimum latency, trig to done with wr_ready held at 1: N*N+1 cycles (10 for N=3).
- trig while in DRAIN or DONE: ignored. The buffer is not overwritten.
- npu_ack held high across a return to IDLE: no retrigger. A new capture requires ack to fall and rise again.
- Changes on c_flat or dst_base after capture have no effect.
- Reset asserted mid-DRAIN: wr_valid drops immediately (async). No done pulse. The block restarts in IDLE.
- wr_ready while wr_valid=0: ignored.

Optional Feature:
- Macro NPU_WB_RELU_EN.
- Defined: each captured word is treated as signed DATA_W; negative values are written as 0 and non-negative values pass unchanged (ReLU at capture time).
- Undefined: words are written bit-exact as captured.

Decomposition:
- Shared package npu_pkg holds:
  - DATA_W and N defaults;
  - the state enum npu_wb_state_t {IDLE, DRAIN, DONE};
  - the result-count constant N*N.
- One sub-module, npu_wb_buf: a parallel-load, indexed-read register file of N*N words, with the optional ReLU clamp applied on load.
- FSM, address generation and edge detection stay in npu_writeback.

Test Plan:
- Basic drain:
  - Stimulus: c_flat words = 1..9, dst_base=0x100, wr_ready=1, pulse npu_ack.
  - Response: 9 writes to addr 0x100,0x104,...,0x120 with data 1..9 in consecutive cycles; done pulses 10 cycles after the ack edge.
- Backpressure:
  - Stimulus: wr_ready=0 for 3 cycles on the 5th word.
  - Response: addr 0x110 / data 5 held stable with wr_valid=1 for 4 cycles total; order and count unchanged.
- Ack held and retrigger:
  - Stimulus: npu_ack held high for 30 cycles.
  - Response: exactly one drain and one done. After ack goes low then high again, a second drain occurs.
- Address wrap:
  - Stimulus: dst_base=0xFFFF_FFF8, wr_ready=1.
  - Response: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4, ..., 0x18.
- Reset mid-drain:
  - Stimulus: assert rst=0 after the 4th accepted write.
  - Response: wr_valid=0 and busy=0 asynchronously, no done pulse; a following trig drains all 9 words from idx 0.
- ReLU (NPU_WB_RELU_EN defined):
  - Stimulus: c_flat word 3 = 0xFFFF_FFFE (-2), word 4 = 7.
  - Response: writes 0 and 7 respectively. With the macro undefined, 0xFFFF_FFFE is written unchanged.
